// File: rtl/sync_filter_multi.sv
// -----------------------------------------------------------------------------
// sync_filter_multi
//
// Multi-channel asynchronous-input conditioner. Each of WIDTH channels passes
// through a STAGES-deep synchronizer chain. A per-channel glitch filter then
// only lets sync_out follow the synchronized input once the input has differed
// from sync_out for FILTER_LEN consecutive clock edges. Every change of
// sync_out comes with a registered one-cycle rise or fall pulse.
//
// Parameters:
//   WIDTH      number of independent channels (>= 1)
//   STAGES     synchronizer flop depth (>= 2, checked at elaboration)
//   FILTER_LEN consecutive mismatching edges before sync_out flips
//              (>= 1, checked at elaboration)
//   RST_VAL    reset value of the sync stages and of sync_out
//
// Ports:
//   clk        system clock
//   n_rst      asynchronous, active-low reset
//   async_in   [WIDTH] asynchronous inputs
//   sync_out   [WIDTH] synchronized, filtered level
//   rise       [WIDTH] one-cycle pulse when sync_out[i] goes 0->1
//   fall       [WIDTH] one-cycle pulse when sync_out[i] goes 1->0
//   changed    OR of all rise/fall pulses
//
// Optional build macro SYNC_FILTER_STATS_EN adds:
//   stats_clr  synchronous clear of glitch_cnt (wins over increment)
//   glitch_cnt [8] saturating count of cycles in which at least one channel
//              rejected a glitch
// -----------------------------------------------------------------------------
module sync_filter_multi #(
  parameter int               WIDTH      = 4,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 3,
  parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             n_rst,
`ifdef SYNC_FILTER_STATS_EN
  input  logic             stats_clr,
`endif
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
`ifdef SYNC_FILTER_STATS_EN
  output logic [7:0]       glitch_cnt,
`endif
  output logic             changed
);

  // Counter holds 0 .. FILTER_LEN-1; never narrower than one bit.
  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter_multi: STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("sync_filter_multi: FILTER_LEN must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Synchronizer chain: plain flop-to-flop, no logic between stages.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] s_last;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= async_in;
      for (int k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign s_last = stage_q[STAGES-1];

  // ---------------------------------------------------------------------------
  // Per-channel glitch filter
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] flip;
`ifdef SYNC_FILTER_STATS_EN
  logic [WIDTH-1:0] busy;
`endif

  assign mismatch = s_last ^ sync_q;

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Flip on the edge that would otherwise push the count past its maximum.
    assign flip[gi] = mismatch[gi] && (cnt_q == CNT_MAX);
`ifdef SYNC_FILTER_STATS_EN
    assign busy[gi] = (cnt_q != '0);
`endif

    // Match or completed flip both return the counter to 0.
    always_comb begin
      cnt_d = '0;
      if (mismatch[gi] && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign sync_d = sync_q ^ flip;
  assign rise_d = flip & s_last;
  assign fall_d = flip & ~s_last;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync_out = sync_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign changed  = |(rise_q | fall_q);

  // ---------------------------------------------------------------------------
  // Optional glitch statistics
  // ---------------------------------------------------------------------------
`ifdef SYNC_FILTER_STATS_EN
  logic [7:0] glitch_q, glitch_d;
  logic       glitch_seen;

  // A channel that had started counting and now matches again has just
  // rejected a glitch; any number of such channels counts once per cycle.
  assign glitch_seen = |(busy & ~mismatch);

  always_comb begin
    glitch_d = glitch_q;
    if (stats_clr) begin
      glitch_d = '0;
    end else if (glitch_seen && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule
